// File: rtl/kb_code_ext.sv
// kb_code_ext: PS/2 scan-code decoder tracking E0/F0 prefixes with a prefix timeout,
// feeding decoded {ext, brk, code} words into a first-word-fall-through FIFO.
module kb_code_ext #(
    parameter int W_SIZE    = 2,
    parameter int MODE      = 0,
    parameter int TO_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_out,
    input  logic       rd_key_code,
    input  logic       clr_ovf,
    output logic [9:0] key_code,
    output logic       kb_buf_empty,
    output logic       kb_buf_full,
    output logic       kb_ovf
);
    localparam int DEPTH = 2 ** W_SIZE;
    localparam int TW    = $clog2(TO_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_to_cnt, w_to_nxt;
    logic [9:0]        r_mem [DEPTH];
    logic [W_SIZE-1:0] r_wptr, r_rptr;
    logic [W_SIZE:0]   r_cnt;
    logic              r_ovf;
    logic              w_prefix, w_ext, w_brk, w_emit, w_wr_req, w_full, w_rd, w_wr;
    logic [9:0]        w_word;

    assign w_prefix = scan_out == 8'hE0 || scan_out == 8'hF0;
    assign w_ext    = r_state == S_EXT || r_state == S_EXT_BRK;
    assign w_brk    = r_state == S_BRK || r_state == S_EXT_BRK;
    assign w_emit   = scan_done_tick && !w_prefix;
    assign w_word   = {w_ext, w_brk, scan_out};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    // Counter only advances while a prefix is pending and no byte arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = '0;
        if (scan_done_tick)
            w_state_nxt = !w_prefix ? S_IDLE :
                          scan_out == 8'hF0 ? (r_state == S_IDLE ? S_BRK :
                                               r_state == S_EXT  ? S_EXT_BRK : r_state) :
                          (r_state == S_IDLE ? S_EXT : r_state);
        else if (r_state != S_IDLE) begin
            if (r_to_cnt == TW'(TO_CYCLES - 1))
                w_state_nxt = S_IDLE;
            else
                w_to_nxt = r_to_cnt + TW'(1);
        end
    end

    assign w_wr_req = w_emit && (w_brk ? MODE != 1 : MODE != 0);
    assign w_full   = r_cnt == (W_SIZE + 1)'(DEPTH);
    assign w_rd     = rd_key_code && r_cnt != '0;
    assign w_wr     = w_wr_req && (!w_full || w_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + {{W_SIZE{1'b0}}, w_wr} - {{W_SIZE{1'b0}}, w_rd};
            r_ovf <= (w_wr_req && !w_wr) || (r_ovf && !clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_word;
    end

    assign kb_buf_empty = r_cnt == '0;
    assign kb_buf_full  = w_full;
    assign kb_ovf       = r_ovf;
    assign key_code     = kb_buf_empty ? '0 : r_mem[r_rptr];
endmodule
